// File: rtl/aes_encryptor_pkg.sv
// -----------------------------------------------------------------------------
// AES_pkg
// Shared types, constants and round-function helpers for the iterative
// AES-128 encryption core.
//   byte_t / state_t : one byte, and the 16-byte state. state_t is a packed
//                      array indexed [0:15], so byte 0 sits in bits [127:120].
//                      Byte n maps to s[r][c] with n = 4c+r.
//   fsm_state_e      : controller states, also exported on a debug port.
//   SBOX, RCON       : the forward S-box and the round constants.
//   xtime, sub_bytes, shift_rows, mix_columns, sub_word, rot_word.
// -----------------------------------------------------------------------------
package AES_pkg;

   localparam int NR    = 10;
   localparam int BLK_W = 128;

   typedef logic [7:0]  byte_t;
   typedef byte_t [0:15] state_t;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } fsm_state_e;

   localparam byte_t SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   localparam byte_t RCON [10] = '{
      8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
   };

   // Multiply by x in GF(2^8), reduction polynomial 0x11b.
   function automatic byte_t xtime(input byte_t b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic state_t sub_bytes(input state_t s);
      state_t o;
      for (int i = 0; i < 16; i++) begin
         o[i] = SBOX[s[i]];
      end
      return o;
   endfunction

   // Row r rotates left by r columns: s'[r][c] = s[r][(c+r) mod 4].
   function automatic state_t shift_rows(input state_t s);
      state_t o;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[4*c + r] = s[4*((c + r) % 4) + r];
         end
      end
      return o;
   endfunction

   function automatic state_t mix_columns(input state_t s);
      state_t o;
      byte_t  a0, a1, a2, a3;
      for (int c = 0; c < 4; c++) begin
         a0 = s[4*c];
         a1 = s[4*c + 1];
         a2 = s[4*c + 2];
         a3 = s[4*c + 3];
         o[4*c]     = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
         o[4*c + 1] = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
         o[4*c + 2] = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
         o[4*c + 3] = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
      end
      return o;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
   endfunction

   function automatic logic [31:0] rot_word(input logic [31:0] w);
      return {w[23:0], w[31:24]};
   endfunction

endpackage

// File: rtl/aes_encryptor_key_expand.sv
// -----------------------------------------------------------------------------
// aes_key_expand
// Combinational AES-128 key-schedule step: derives the next round key from
// the current one.
//   rk_i      [127:0] current round key (w0 in bits [127:96])
//   rcon_i    [7:0]   round constant for the key being produced
//   rk_next_o [127:0] next round key {w4, w5, w6, w7}
// -----------------------------------------------------------------------------
module aes_key_expand
   import AES_pkg::*;
(
   input  logic [127:0] rk_i,
   input  logic [7:0]   rcon_i,
   output logic [127:0] rk_next_o
);

   logic [31:0] w0, w1, w2, w3;
   logic [31:0] w4, w5, w6, w7;

   always_comb begin
      w0 = rk_i[127:96];
      w1 = rk_i[95:64];
      w2 = rk_i[63:32];
      w3 = rk_i[31:0];
      w4 = w0 ^ sub_word(rot_word(w3)) ^ {rcon_i, 24'h000000};
      w5 = w1 ^ w4;
      w6 = w2 ^ w5;
      w7 = w3 ^ w6;
      rk_next_o = {w4, w5, w6, w7};
   end

endmodule

// File: rtl/aes_encryptor.sv
// -----------------------------------------------------------------------------
// aes_encryptor
// Iterative AES-128 encryption core: one round per clock, round keys expanded
// on the fly. A single-cycle req in IDLE latches data/key; ten edges later the
// ciphertext appears on out_data with a one-cycle enable pulse. out_data holds
// until the next completion or reset.
//   clk       clock, rising edge
//   rstN      asynchronous reset, ACTIVE-HIGH despite the name
//   req       start request, sampled on rising clk
//   data      plaintext, data[127:120] = byte 0
//   key       cipher key, same byte order
//   enable    result-valid pulse, one cycle
//   out_data  ciphertext, same byte order
//   dbg_state current controller state (IDLE/RUN), for observation only
// Build option AES_REQ_RESTART_EN: when defined, req during RUN discards the
// block in flight and restarts with the new data/key; when undefined, req
// during RUN is ignored.
// Handshake: req is a level sampled every rising edge; it is only acted upon
// in IDLE (or in RUN with the restart option). enable has no back-pressure.
// -----------------------------------------------------------------------------
module aes_encryptor
   import AES_pkg::*;
(
   input  logic             clk,
   input  logic             rstN,
   input  logic             req,
   input  logic [BLK_W-1:0] data,
   input  logic [BLK_W-1:0] key,
   output logic             enable,
   output logic [BLK_W-1:0] out_data,
   output fsm_state_e       dbg_state
);

   localparam logic [3:0] LAST_RND = 4'(NR);

   fsm_state_e       state_q;
   logic [3:0]       rnd_q;
   state_t           st_q;
   logic [BLK_W-1:0] rk_q;
   logic             enable_q;
   logic [BLK_W-1:0] out_data_q;

   logic [7:0]       rcon;
   logic [BLK_W-1:0] rk_d;
   state_t           sr_st;
   state_t           st_d;
   logic [BLK_W-1:0] out_d;

   // rnd_q is 1..10 while running; 0 in IDLE gives a harmless zero constant.
   always_comb begin
      rcon = 8'h00;
      if (rnd_q != 4'd0 && rnd_q <= LAST_RND) begin
         rcon = RCON[rnd_q - 4'd1];
      end
   end

   aes_key_expand u_key_expand (
      .rk_i      (rk_q),
      .rcon_i    (rcon),
      .rk_next_o (rk_d)
   );

   // Middle rounds use MixColumns; the last round taps ShiftRows directly.
   always_comb begin
      sr_st = shift_rows(sub_bytes(st_q));
      st_d  = mix_columns(sr_st) ^ rk_d;
      out_d = sr_st ^ rk_d;
   end

   always_ff @(posedge clk or posedge rstN) begin
      if (rstN) begin
         state_q    <= IDLE;
         rnd_q      <= 4'd0;
         st_q       <= '0;
         rk_q       <= '0;
         enable_q   <= 1'b0;
         out_data_q <= '0;
      end else begin
         enable_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (req) begin
                  st_q    <= data ^ key;
                  rk_q    <= key;
                  rnd_q   <= 4'd1;
                  state_q <= RUN;
               end
            end
            RUN: begin
`ifdef AES_REQ_RESTART_EN
               if (req) begin
                  st_q  <= data ^ key;
                  rk_q  <= key;
                  rnd_q <= 4'd1;
               end else
`endif
               if (rnd_q == LAST_RND) begin
                  out_data_q <= out_d;
                  enable_q   <= 1'b1;
                  rnd_q      <= 4'd0;
                  state_q    <= IDLE;
               end else begin
                  st_q  <= st_d;
                  rk_q  <= rk_d;
                  rnd_q <= rnd_q + 4'd1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign enable    = enable_q;
   assign out_data  = out_data_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_aes_encryptor.sv
// -----------------------------------------------------------------------------
// tb_aes_encryptor
// Directed-vector bench for aes_encryptor using the FIPS-197 known answers.
// A negedge monitor pops expected ciphertexts from exp_q on every enable
// pulse; driver tasks check latency, pulse width and output hold.
// -----------------------------------------------------------------------------
module tb_aes_encryptor;
   import AES_pkg::*;

   localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

   logic         clk  = 1'b0;
   logic         rstN = 1'b1;
   logic         req  = 1'b0;
   logic [127:0] data = '0;
   logic [127:0] key  = '0;
   logic         enable;
   logic [127:0] out_data;
   fsm_state_e   dbg_state;

   int n_total = 0;
   int n_bad   = 0;
   logic [127:0] exp_q[$];

   // clock / reset
   always #5 clk = ~clk;

   aes_encryptor dut (
      .clk       (clk),
      .rstN      (rstN),
      .req       (req),
      .data      (data),
      .key       (key),
      .enable    (enable),
      .out_data  (out_data),
      .dbg_state (dbg_state)
   );

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
      n_total++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s got=%h want=%h", tag, got, want);
      end
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (enable === 1'b1) begin
         if (exp_q.size() == 0) check("spurious_enable", {127'd0, enable}, 128'd0);
         else check("ciphertext", out_data, exp_q.pop_front());
      end
   end

   // drivers
   function automatic logic [127:0] junk();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic send_req(input logic [127:0] d, input logic [127:0] k);
      @(negedge clk);
      req  = 1'b1;
      data = d;
      key  = k;
      @(posedge clk);
      #1;
      req  = 1'b0;
      data = junk();
      key  = junk();
   endtask

   task automatic wait_enable(output int n);
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (enable !== 1'b1 && n < 40);
   endtask

   task automatic check_pulse(input logic [127:0] ct);
      check("en_high", {127'd0, enable}, 128'd1);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         check("en_one_cycle", {127'd0, enable}, 128'd0);
         check("out_hold", out_data, ct);
      end
   endtask

   task automatic run_block(input logic [127:0] d, input logic [127:0] k, input logic [127:0] ct);
      int n;
      exp_q.push_back(ct);
      send_req(d, k);
      check("state_run", {127'd0, dbg_state}, {127'd0, RUN});
      wait_enable(n);
      check("latency", n, 10);
      check_pulse(ct);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      int n;
      // reset state
      #2;
      check("rst_enable", {127'd0, enable}, 128'd0);
      check("rst_out", out_data, 128'd0);
      check("rst_state", {127'd0, dbg_state}, {127'd0, IDLE});
      @(negedge clk);
      rstN = 1'b0;
      repeat (2) @(negedge clk);

      // known-answer vectors
      run_block(C1_PT, C1_KEY, C1_CT);
      run_block(B_PT, B_KEY, B_CT);
      run_block(128'd0, 128'd0, Z_CT);

`ifndef AES_REQ_RESTART_EN
      // back-to-back with req held high
      exp_q.push_back(C1_CT);
      exp_q.push_back(B_CT);
      @(negedge clk);
      req  = 1'b1;
      data = C1_PT;
      key  = C1_KEY;
      @(posedge clk);
      #1;
      data = B_PT;
      key  = B_KEY;
      wait_enable(n);
      check("b2b_latency", n, 10);
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
         if (n == 1) req = 1'b0;
      end while (enable !== 1'b1 && n < 40);
      check("b2b_gap", n, 11);
      check_pulse(B_CT);
`endif

      // async reset in the middle of a block
      send_req(C1_PT, C1_KEY);
      repeat (5) @(posedge clk);
      #2;
      rstN = 1'b1;
      #1;
      check("abort_enable", {127'd0, enable}, 128'd0);
      check("abort_out", out_data, 128'd0);
      check("abort_state", {127'd0, dbg_state}, {127'd0, IDLE});
      repeat (3) @(negedge clk);
      rstN = 1'b0;
      repeat (15) @(posedge clk);
      #1;
      check("abort_out_later", out_data, 128'd0);
      run_block(C1_PT, C1_KEY, C1_CT);

      // req while running
`ifdef AES_REQ_RESTART_EN
      exp_q.push_back(B_CT);
`else
      exp_q.push_back(C1_CT);
`endif
      send_req(C1_PT, C1_KEY);
      repeat (2) @(posedge clk);
      send_req(B_PT, B_KEY);
      wait_enable(n);
`ifdef AES_REQ_RESTART_EN
      check("restart_latency", n, 10);
      check_pulse(B_CT);
`else
      check("ignore_latency", n, 7);
      check_pulse(C1_CT);
`endif
      repeat (15) @(posedge clk);
      #1;
      check("idle_after", {127'd0, dbg_state}, {127'd0, IDLE});

      check("queue_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
